chip_proto_transmitter: RTL and testbench
=========================================

# chip_proto_transmitter

Transmit-side framer for the single-byte command protocol. It serialises one response or command packet as a command byte, 0 to BUFFER_LENGTH data bytes and a trailing CRC8 byte. Bytes go one at a time to the byte-level transmitter (UART TX) over a start/busy handshake. It sits between the command handlers, which supply cmd, data and size, and the UART TX. It is the mirror of the receive-side packet parser.

## Interface
- BYTE_LENGTH, 8, bits per byte
- BUFFER_LENGTH, 6, maximum data bytes per packet, command and CRC excluded
- TOTAL_REQUARED_BITS, BYTE_LENGTH*BUFFER_LENGTH, width of out_data
- COUNTER_SIZE, 8, width of size and byte counters
- TIMEOUT_COUNTER_SIZE, 32, timeout counter width
- TIMEOUT_MAX_VAL, 10000000, handshake timeout in clk cycles

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- send  in  1  start request, acted on at rising edge
- out_cmd  in  8  command byte
- out_data  in  TOTAL_REQUARED_BITS  payload; byte i = out_data[8i+7:8i]
- out_data_size  in  COUNTER_SIZE  payload byte count
- flush  in  1  abort request, acted on at rising edge
- tx_byte  out  8  byte presented to UART TX
- tx_start  out  1  one-cycle request to UART TX
- tx_busy  in  1  UART TX busy
- busy  out  1  packet in progress
- complete  out  1  packet fully sent
- timeout_err  out  1  handshake timeout occurred

## Operation
- FSM states: IDLE, SEND_BYTE, WAIT_ACK, WAIT_DONE, DONE.
- Edge detectors on send and flush use registered previous values; each edge is a one-cycle event.
- IDLE or DONE, on a send edge:
  - Latch out_cmd, out_data and the size; a size above BUFFER_LENGTH is clamped to BUFFER_LENGTH.
  - Clear the CRC to 0x00, clear complete and timeout_err, set byte_idx=0, go to SEND_BYTE.
- A send edge during any other state is ignored.
- Byte sequence: cmd, then data[0..size-1] (LSB byte first), then CRC.
- SEND_BYTE: drive tx_byte with the current byte, pulse tx_start for one cycle, go to WAIT_ACK.
  - For cmd and data bytes only, update crc <= crc8_byte(crc, byte).
- WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0.
  - If more bytes remain, advance and return to SEND_BYTE.
  - After the CRC byte, go to DONE.
- DONE: complete=1 and busy=0; held until the next send edge or a flush edge.
- CRC8 definition: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR. It is computed over cmd followed by the data bytes and matches the receive-side CRC8.
- tx_byte holds its value between tx_start pulses.

## Timing
- Reset values: tx_byte=0, tx_start=0, busy=0, complete=0, timeout_err=0, state IDLE, crc=0, counters=0.
- Send edge in cycle N: busy=1 from N+1, tx_start=1 with tx_byte=cmd in cycle N+1.
- tx_busy falling in cycle M: the next byte's tx_start is in cycle M+1. The inter-byte gap is 1 cycle beyond the UART time.
- After the CRC byte's tx_busy falls in cycle M: complete=1 and busy=0 from cycle M+1.
- Size 0 sends 2 bytes (cmd, CRC). Size at maximum sends BUFFER_LENGTH+2 bytes.
- A flush edge in any state returns the block to IDLE next cycle. It clears busy, complete, tx_start and the counters; tx_byte holds its value. Flush wins over a simultaneous send edge.
- An asynchronous reset mid-packet stops immediately; no partial-packet recovery.
- tx_start is never asserted while in WAIT_ACK or WAIT_DONE.

## Configuration
- CHIP_PROTO_TX_TIMEOUT_EN defined:
  - The counter runs in WAIT_ACK and WAIT_DONE and is cleared on every state change.
  - On reaching TIMEOUT_MAX_VAL: go to IDLE, set timeout_err=1 (held until the next send edge or reset), busy=0, complete=0.
- CHIP_PROTO_TX_TIMEOUT_EN undefined: the counter is absent, timeout_err is tied to 0, and the block waits indefinitely.

## Structure
- Shared package holds:
  - BYTE_LENGTH and the CRC8 polynomial/init constants
  - the FSM state encoding
  - the crc8_byte(crc, byte) function: 8-step unrolled, combinational
- Natural sub-module: chip_proto_tx_crc8, a registered per-byte CRC accumulator with clear and update strobes.
- The FSM and byte selection stay in the top level.

## Test plan
- cmd 0x11, size 1, data byte 0xA5, UART model with 10-cycle busy -> tx bytes 0x11, 0xA5, 0x30; complete=1 one cycle after the last tx_busy fall.
- cmd 0xF2, size 0 -> exactly 2 bytes, 0xF2 and 0xD0; busy high for the whole frame.
- out_data_size=9 with BUFFER_LENGTH=6 -> exactly 8 bytes sent (clamp); second send edge while busy -> ignored, no extra bytes.
- Flush edge during WAIT_DONE of byte 2 -> IDLE next cycle, busy=0, complete=0, no further tx_start; a following send restarts from cmd with CRC recomputed.
- With the macro and TIMEOUT_MAX_VAL=50, tx_busy held 0 after the first tx_start -> timeout_err=1 and busy=0 after 50 cycles; without the macro -> remains in WAIT_ACK.
- Reset asserted mid-frame -> all outputs return to 0 asynchronously; next send produces a full correct frame.

Source files
------------

// File: rtl/chip_proto_transmitter_pkg.sv
// chip_proto_transmitter_pkg: shared constants, FSM encoding and CRC8 step for the TX framer
package chip_proto_transmitter_pkg;
  localparam int BYTE_LENGTH = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_BYTE = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ CRC8_POLY : {c[6:0], 1'b0};
    return c;
  endfunction
endpackage

// File: rtl/chip_proto_tx_crc8.sv
// chip_proto_tx_crc8: registered CRC8 accumulator, one byte folded in per update strobe
module chip_proto_tx_crc8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       upd,
  input  logic [7:0] data_in,
  output logic [7:0] crc
);
  import chip_proto_transmitter_pkg::*;
  // Clear takes priority so every frame starts from the init value
  always_ff @(posedge clk or negedge reset)
    if (!reset) crc <= CRC8_INIT;
    else if (clr) crc <= CRC8_INIT;
    else if (upd) crc <= crc8_byte(crc, data_in);
endmodule

// File: rtl/chip_proto_transmitter.sv
// chip_proto_transmitter: frames cmd, payload and CRC8 into a byte stream for the UART TX; define CHIP_PROTO_TX_TIMEOUT_EN for the handshake timeout
module chip_proto_transmitter #(
  parameter int BYTE_LENGTH          = 8,
  parameter int BUFFER_LENGTH        = 6,
  parameter int TOTAL_REQUARED_BITS  = BYTE_LENGTH * BUFFER_LENGTH,
  parameter int COUNTER_SIZE         = 8,
  parameter int TIMEOUT_COUNTER_SIZE = 32,
  parameter int TIMEOUT_MAX_VAL      = 10000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           send,
  input  logic [7:0]                     out_cmd,
  input  logic [TOTAL_REQUARED_BITS-1:0] out_data,
  input  logic [COUNTER_SIZE-1:0]        out_data_size,
  input  logic                           flush,
  output logic [7:0]                     tx_byte,
  output logic                           tx_start,
  input  logic                           tx_busy,
  output logic                           busy,
  output logic                           complete,
  output logic                           timeout_err
);
  import chip_proto_transmitter_pkg::*;
  localparam logic [COUNTER_SIZE-1:0] MAX_SIZE = COUNTER_SIZE'(BUFFER_LENGTH);
  logic [2:0] state;
  logic send_q, flush_q, send_edge, flush_edge, start_frame, tmo_hit;
  logic last_byte, next_is_data, crc_upd;
  logic [COUNTER_SIZE-1:0] size_q, byte_idx;
  logic [TOTAL_REQUARED_BITS-1:0] data_q;
  logic [7:0] crc;
  assign send_edge    = send & ~send_q;
  assign flush_edge   = flush & ~flush_q;
  assign start_frame  = send_edge && !flush_edge && (state == ST_IDLE || state == ST_DONE);
  assign tx_start     = state == ST_SEND_BYTE;
  assign busy         = state == ST_SEND_BYTE || state == ST_WAIT_ACK || state == ST_WAIT_DONE;
  assign complete     = state == ST_DONE;
  assign last_byte    = byte_idx > size_q;
  assign next_is_data = byte_idx < size_q;
  assign crc_upd      = tx_start && !last_byte;
  chip_proto_tx_crc8 u_crc (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_frame),
    .upd     (crc_upd),
    .data_in (tx_byte),
    .crc     (crc)
  );
  // Previous send/flush levels for rising-edge detection
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      send_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      send_q  <= send;
      flush_q <= flush;
    end
  // Frame sequencer: byte_idx 0 is cmd, 1..size the payload, size+1 the CRC
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= ST_IDLE;
      tx_byte  <= '0;
      data_q   <= '0;
      size_q   <= '0;
      byte_idx <= '0;
    end else if (flush_edge || tmo_hit) begin
      state    <= ST_IDLE;
      size_q   <= '0;
      byte_idx <= '0;
    end else if (start_frame) begin
      state    <= ST_SEND_BYTE;
      tx_byte  <= out_cmd;
      data_q   <= out_data;
      size_q   <= out_data_size > MAX_SIZE ? MAX_SIZE : out_data_size;
      byte_idx <= '0;
    end else if (state == ST_SEND_BYTE) begin
      state <= ST_WAIT_ACK;
    end else if (state == ST_WAIT_ACK && tx_busy) begin
      state <= ST_WAIT_DONE;
    end else if (state == ST_WAIT_DONE && !tx_busy) begin
      state <= last_byte ? ST_DONE : ST_SEND_BYTE;
      if (!last_byte) begin
        byte_idx <= byte_idx + 1'b1;
        tx_byte  <= next_is_data ? data_q[7:0] : crc;
        if (next_is_data) data_q <= data_q >> BYTE_LENGTH;
      end
    end
`ifdef CHIP_PROTO_TX_TIMEOUT_EN
  logic [TIMEOUT_COUNTER_SIZE-1:0] tmo_cnt;
  logic stay;
  assign stay    = (state == ST_WAIT_ACK && !tx_busy) || (state == ST_WAIT_DONE && tx_busy);
  assign tmo_hit = stay && tmo_cnt == TIMEOUT_COUNTER_SIZE'(TIMEOUT_MAX_VAL - 1);
  // Cycles spent in the current wait state; any state change restarts it
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmo_cnt <= '0;
    else tmo_cnt <= (stay && !flush_edge && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
  // Sticky timeout flag, cleared only by the next accepted send
  always_ff @(posedge clk or negedge reset)
    if (!reset) timeout_err <= 1'b0;
    else if (start_frame) timeout_err <= 1'b0;
    else if (tmo_hit && !flush_edge) timeout_err <= 1'b1;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_chip_proto_transmitter.sv
// tb_chip_proto_transmitter: randomized and directed frames checked against a bit-serial CRC8 reference
module tb_chip_proto_transmitter;
  localparam int BL = 6;
  logic clk = 1'b0, reset = 1'b0, send = 1'b0, flush = 1'b0, tx_busy = 1'b0;
  logic [7:0] out_cmd = '0, out_data_size = '0;
  logic [47:0] out_data = '0;
  logic [7:0] tx_byte;
  logic tx_start, busy, complete, timeout_err;
  int n_cmp = 0, n_bad = 0, cyc = 0, busy_len = 10, done_cyc = 0;
  bit uart_on = 1'b1, busy_held, finished;
  logic done_busy;
  logic [11:0] first_vec;
  logic [7:0] got[$], exp_q[$];
  int starts[$], falls[$];

  chip_proto_transmitter #(.TIMEOUT_MAX_VAL(50)) dut (
    .clk(clk), .reset(reset), .send(send), .out_cmd(out_cmd), .out_data(out_data),
    .out_data_size(out_data_size), .flush(flush), .tx_byte(tx_byte), .tx_start(tx_start),
    .tx_busy(tx_busy), .busy(busy), .complete(complete), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART TX model: goes busy in the start cycle, drops busy busy_len cycles later
  initial forever begin
    @(posedge clk);
    #1;
    if (uart_on && tx_start === 1'b1) begin
      got.push_back(tx_byte);
      starts.push_back(cyc);
      tx_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1;
      tx_busy = 1'b0;
      falls.push_back(cyc);
    end
  end

  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] r = 8'h00;
    logic fb;
    for (int k = 0; k < n; k++)
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ exp_q[k][b];
        r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return r;
  endfunction

  function automatic void build_exp(input logic [7:0] c, input logic [47:0] d, input logic [7:0] sz);
    int n = (sz > BL) ? BL : int'(sz);
    exp_q.delete();
    exp_q.push_back(c);
    for (int i = 0; i < n; i++) exp_q.push_back(d[8*i +: 8]);
    exp_q.push_back(ref_crc(exp_q.size()));
  endfunction

  task automatic start_send(input logic [7:0] c, input logic [47:0] d, input logic [7:0] sz);
    got.delete();
    starts.delete();
    falls.delete();
    out_cmd = c;
    out_data = d;
    out_data_size = sz;
    @(negedge clk);
    send = 1'b1;
    @(posedge clk);
    #1;
    first_vec = {busy, tx_start, tx_byte, complete, timeout_err};
    send = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [47:0] d, input logic [7:0] sz, input bit resend);
    start_send(c, d, sz);
    busy_held = 1'b1;
    finished = 1'b0;
    for (int t = 0; t < 800 && !finished; t++) begin
      @(posedge clk);
      #1;
      if (resend && t == 20) send = 1'b1;
      if (resend && t == 21) send = 1'b0;
      if (complete === 1'b1) begin
        finished = 1'b1;
        done_cyc = cyc;
        done_busy = busy;
      end else if (busy !== 1'b1) busy_held = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({tx_byte, tx_start, busy, complete, timeout_err} !== 12'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 000", {tx_byte, tx_start, busy, complete, timeout_err});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic;
    busy_len = 10;
    run_frame(8'h11, 48'hA5, 8'd1, 1'b0);
    exp_q = {8'h11, 8'hA5, 8'h30};
    n_cmp++;
    if (first_vec !== {1'b1, 1'b1, 8'h11, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_first: got %h want %h", first_vec, {1'b1, 1'b1, 8'h11, 1'b0, 1'b0});
    end
    n_cmp++;
    if (finished !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %0d want 1", finished); end
    n_cmp++;
    if (got.size() != 3) begin n_bad++; $display("FAIL basic_len: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    for (int k = 1; k < starts.size() && k <= falls.size(); k++) begin
      n_cmp++;
      if (starts[k] != falls[k-1] + 1) begin n_bad++; $display("FAIL basic_gap%0d: got %0d want %0d", k, starts[k], falls[k-1] + 1); end
    end
    n_cmp++;
    if (falls.size() == 0 || done_cyc != falls[falls.size()-1] + 1 || done_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_complete_time: got cyc %0d busy %b want one after last fall, busy 0", done_cyc, done_busy);
    end
  endtask

  task automatic test_size0;
    busy_len = 4;
    run_frame(8'hF2, 48'({$urandom(), $urandom()}), 8'd0, 1'b0);
    exp_q = {8'hF2, 8'hD0};
    n_cmp++;
    if (got.size() != 2) begin n_bad++; $display("FAIL size0_len: got %0d want 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL size0_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    n_cmp++;
    if (busy_held !== 1'b1 || finished !== 1'b1) begin
      n_bad++;
      $display("FAIL size0_busy: got held %b done %b want 1 1", busy_held, finished);
    end
  endtask

  task automatic test_clamp_resend;
    logic [47:0] d;
    d = 48'({$urandom(), $urandom()});
    busy_len = 6;
    run_frame(8'h5C, d, 8'd9, 1'b1);
    build_exp(8'h5C, d, 8'd9);
    n_cmp++;
    if (got.size() != 8) begin n_bad++; $display("FAIL clamp_len: got %0d want 8", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL clamp_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush;
    logic [47:0] d;
    busy_len = 10;
    start_send(8'h3B, 48'h0000_0077_6655, 8'd3);
    for (int t = 0; t < 200 && starts.size() < 2; t++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, complete, tx_start} !== 3'b000) begin
      n_bad++;
      $display("FAIL flush_idle: got %b want 000", {busy, complete, tx_start});
    end
    flush = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (got.size() != 2 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_quiet: got %0d bytes busy %b want 2 bytes busy 0", got.size(), busy);
    end
    d = 48'({$urandom(), $urandom()});
    run_frame(8'h3B, d, 8'd4, 1'b0);
    build_exp(8'h3B, d, 8'd4);
    n_cmp++;
    if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL flush_restart_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL flush_restart_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout;
    int t;
    int extra;
    uart_on = 1'b0;
    tx_busy = 1'b0;
    start_send(8'h9E, 48'h1234, 8'd2);
    n_cmp++;
    if (first_vec[10] !== 1'b1) begin n_bad++; $display("FAIL timeout_first_start: got %b want 1", first_vec[10]); end
`ifdef CHIP_PROTO_TX_TIMEOUT_EN
    t = 0;
    while (t < 300 && busy === 1'b1) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (t != 51) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 51", t); end
    n_cmp++;
    if ({timeout_err, busy, complete} !== 3'b100) begin
      n_bad++;
      $display("FAIL timeout_flags: got %b want 100", {timeout_err, busy, complete});
    end
`else
    extra = 0;
    for (t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (tx_start === 1'b1) extra++;
    end
    n_cmp++;
    if ({busy, timeout_err} !== 2'b10 || extra != 0) begin
      n_bad++;
      $display("FAIL timeout_wait: got busy/err %b starts %0d want 10 starts 0", {busy, timeout_err}, extra);
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`endif
    uart_on = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_async_reset;
    logic [47:0] d;
    busy_len = 8;
    start_send(8'hC4, 48'hDEAD_BEEF_0102, 8'd5);
    repeat (25) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({tx_byte, tx_start, busy, complete, timeout_err} !== 12'h0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 000", {tx_byte, tx_start, busy, complete, timeout_err});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    d = 48'({$urandom(), $urandom()});
    run_frame(8'h6A, d, 8'd6, 1'b0);
    build_exp(8'h6A, d, 8'd6);
    n_cmp++;
    if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL async_after_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL async_after_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    logic [7:0] c, sz;
    logic [47:0] d;
    for (int f = 0; f < 10; f++) begin
      c = 8'($urandom());
      d = 48'({$urandom(), $urandom()});
      sz = 8'($urandom_range(0, 9));
      busy_len = $urandom_range(2, 12);
      run_frame(c, d, sz, 1'b0);
      build_exp(c, d, sz);
      n_cmp++;
      if (first_vec !== {1'b1, 1'b1, c, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL rand%0d_first: got %h want %h", f, first_vec, {1'b1, 1'b1, c, 1'b0, 1'b0});
      end
      n_cmp++;
      if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL rand%0d_len: got %0d want %0d", f, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, i, got[i], exp_q[i]); end
      end
      n_cmp++;
      if (falls.size() == 0 || done_cyc != falls[falls.size()-1] + 1 || done_busy !== 1'b0 || busy_held !== 1'b1) begin
        n_bad++;
        $display("FAIL rand%0d_timing: got cyc %0d busy %b held %b want one after last fall, 0, 1", f, done_cyc, done_busy, busy_held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_size0();
    test_clamp_resend();
    test_flush();
    test_timeout();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
